// File: rtl/exec_sequencer_pkg.sv
// Shared types and widths for the SIMD execute-unit issue sequencer.
package exec_sequencer_pkg;

   localparam int OP_SEL_WIDTH = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } seq_state_t;

endpackage

// File: rtl/valid_delay_line.sv
// Fixed-depth valid shift register; pending_o flags bits that will still be in flight next cycle.
module valid_delay_line #(
   parameter int DEPTH = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic in_i,
   output logic out_o,
   output logic pending_o
);

   logic [DEPTH-1:0] pipe_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) pipe_q <= '0;
      else     pipe_q <= (pipe_q << 1) | DEPTH'(in_i);
   end

   assign out_o     = pipe_q[DEPTH-1];
   // Everything except the stage leaving this cycle.
   assign pending_o = |(pipe_q & ~(DEPTH'(1) << (DEPTH - 1)));

endmodule

// File: rtl/exec_sequencer.sv
// Issue sequencer for the SIMD execute unit: walks operand chunks, aligns dot accumulate to the
// unit's phase, flags result valids and pulses done. SEQ_PERF_CNT_EN adds busy/instruction counters.
module exec_sequencer
   import exec_sequencer_pkg::*;
#(
   parameter int PE_COUNT  = 4,
   parameter int LEN_WIDTH = 8,
   parameter int EXEC_LAT  = 2,
   parameter int DOT_LAT   = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    instr_valid_i,
   output logic                    instr_ready_o,
   input  logic [OP_SEL_WIDTH-1:0] instr_op_i,
   input  logic                    instr_is_dot_i,
   input  logic [LEN_WIDTH-1:0]    instr_len_i,
   output logic                    rd_en_o,
   output logic [LEN_WIDTH-1:0]    rd_idx_o,
   output logic [OP_SEL_WIDTH-1:0] pe_op_o,
   output logic                    dot_prod_en_o,
   output logic                    shift_o,
   output logic                    elem_valid_o,
   output logic                    dot_valid_o,
   output logic                    busy_o,
   output logic                    done_o
`ifdef SEQ_PERF_CNT_EN
   ,
   output logic [31:0]             perf_busy_cycles_o,
   output logic [31:0]             perf_instr_cnt_o
`endif
);

   localparam int ELEM_DEPTH = 1 + EXEC_LAT;

   if (PE_COUNT < 1 || DOT_LAT < 1 || EXEC_LAT < 0 || LEN_WIDTH < 1) begin : g_bad_params
      $error("exec_sequencer: PE_COUNT, DOT_LAT, LEN_WIDTH must be >= 1 and EXEC_LAT >= 0");
   end

   seq_state_t              state_q;
   logic                    phase_q;
   logic                    rd_en_q;
   logic                    dot_en_q;
   logic                    shift_out_q;
   logic                    done_q;
   logic                    is_dot_q;
   logic [LEN_WIDTH-1:0]    rd_idx_q;
   logic [LEN_WIDTH-1:0]    len_q;
   logic [OP_SEL_WIDTH-1:0] op_q;

   logic [LEN_WIDTH-1:0]    len_d;
   logic                    last_read;
   logic                    elem_in, elem_pend;
   logic                    dot_in, dot_pend;
   logic                    drained;

   assign len_d     = (instr_len_i == '0) ? LEN_WIDTH'(1) : instr_len_i;
   assign last_read = (rd_idx_q == len_q - LEN_WIDTH'(1));
   assign elem_in   = rd_en_q & ~is_dot_q;
   // The only dot_prod_en seen in DRAIN is the one for the last chunk.
   assign dot_in    = dot_en_q & (state_q == DRAIN);
   assign drained   = ~(elem_in | elem_pend | dot_in | dot_pend);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         phase_q     <= 1'b0;
         rd_en_q     <= 1'b0;
         dot_en_q    <= 1'b0;
         shift_out_q <= 1'b0;
         done_q      <= 1'b0;
         is_dot_q    <= 1'b0;
         rd_idx_q    <= '0;
         len_q       <= '0;
         op_q        <= '0;
      end else begin
         phase_q     <= ~phase_q;
         dot_en_q    <= rd_en_q & is_dot_q;
         shift_out_q <= rd_en_q & (rd_idx_q == '0);
         done_q      <= 1'b0;
         case (state_q)
            IDLE: begin
               if (instr_valid_i) begin
                  state_q  <= ISSUE;
                  op_q     <= instr_op_i;
                  is_dot_q <= instr_is_dot_i;
                  len_q    <= len_d;
                  rd_idx_q <= '0;
                  // Dot reads land on phase=0 so operands arrive on a phase=1 cycle.
                  rd_en_q  <= instr_is_dot_i ? phase_q : 1'b1;
               end
            end
            ISSUE: begin
               if (rd_en_q && last_read) begin
                  rd_en_q <= 1'b0;
                  state_q <= DRAIN;
               end else begin
                  if (rd_en_q) rd_idx_q <= rd_idx_q + LEN_WIDTH'(1);
                  rd_en_q <= is_dot_q ? phase_q : 1'b1;
               end
            end
            DRAIN: begin
               if (drained) begin
                  state_q <= IDLE;
                  done_q  <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   valid_delay_line #(.DEPTH(ELEM_DEPTH)) u_elem_pipe (
      .clk       (clk),
      .rst       (rst),
      .in_i      (elem_in),
      .out_o     (elem_valid_o),
      .pending_o (elem_pend)
   );

   valid_delay_line #(.DEPTH(DOT_LAT)) u_dot_pipe (
      .clk       (clk),
      .rst       (rst),
      .in_i      (dot_in),
      .out_o     (dot_valid_o),
      .pending_o (dot_pend)
   );

   assign instr_ready_o = (state_q == IDLE);
   assign busy_o        = (state_q != IDLE);
   assign rd_en_o       = rd_en_q;
   assign rd_idx_o      = rd_idx_q;
   assign pe_op_o       = op_q;
   assign dot_prod_en_o = dot_en_q;
   assign shift_o       = shift_out_q;
   assign done_o        = done_q;

`ifdef SEQ_PERF_CNT_EN
   logic [31:0] perf_busy_q;
   logic [31:0] perf_instr_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_busy_q  <= '0;
         perf_instr_q <= '0;
      end else begin
         if (busy_o && perf_busy_q != '1)  perf_busy_q  <= perf_busy_q + 32'd1;
         if (done_q && perf_instr_q != '1) perf_instr_q <= perf_instr_q + 32'd1;
      end
   end

   assign perf_busy_cycles_o = perf_busy_q;
   assign perf_instr_cnt_o   = perf_instr_q;
`endif

endmodule

// File: doc/exec_sequencer.md
Name: exec_sequencer

Overview:
Issue controller for the SIMD execute unit (PE array plus dot-product accumulator). Accepts one vector instruction at a time over a valid/ready handshake and walks its operand chunks through the operand buffer. Drives the execute unit's pe_op, dot_prod_en and shift controls, aligned to the unit's alternating dot-enable phase. Flags when the elementwise and dot-product results are valid, and pulses done when the instruction has fully drained.

Parameters:
PE_COUNT, 4, lanes per chunk; passed through for consistency checks only
LEN_WIDTH, 8, width of the chunk count and of the operand read index
EXEC_LAT, 2, cycles from operands-at-execute-inputs to elem_out valid
DOT_LAT, 2, cycles from the last accumulate cycle to dot_out valid

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
instr_valid  in  1  instruction offered
instr_ready  out  1  sequencer can accept an instruction (high only in IDLE)
instr_op  in  OP_SEL_WIDTH  PE operation
instr_is_dot  in  1  instruction is a dot product
instr_len  in  LEN_WIDTH  number of chunks; 0 treated as 1
rd_en  out  1  operand buffer read strobe; data reaches a/b the next cycle
rd_idx  out  LEN_WIDTH  chunk index being read
pe_op  out  OP_SEL_WIDTH  to execute unit
dot_prod_en  out  1  to execute unit
shift  out  1  to execute unit
elem_valid  out  1  elem_out holds a valid chunk this cycle
dot_valid  out  1  dot_out holds the final dot result this cycle
busy  out  1  state is not IDLE
done  out  1  one-cycle pulse when the instruction has fully drained

Behaviour:
- Reset (async, rst=1): state IDLE. All outputs 0 except instr_ready=1. rd_idx=0. pe_op=0. phase=0. All counters and valid pipes cleared.
- phase: toggles every cycle out of reset. Mirrors the execute unit's internal dot-enable, which is 1 on odd cycles after reset. Accumulate and shift take effect only when phase=1.
- Accept: instr_valid & instr_ready. Latch op, is_dot and len (0 becomes 1). Go to ISSUE; rd_idx=0.
- ISSUE, elementwise: rd_en=1 every cycle, rd_idx increments by 1. After len reads go to DRAIN.
- ISSUE, dot: one read per two cycles. rd_en is asserted when phase=0, so the operands reach the execute unit on a phase=1 cycle.
- pe_op is held at the latched op from acceptance until done.
- dot_prod_en is asserted in the cycle after each dot read.
- shift accompanies the first chunk only (it clears/restarts the accumulator) and is 0 for later chunks.
- elem_valid = rd_en delayed by 1+EXEC_LAT cycles (shift register). It is 0 for dot instructions.
- DRAIN: wait until the valid pipe is empty. For dot, also wait DOT_LAT cycles after the last dot_prod_en; dot_valid pulses for one cycle at the end of that wait.
- After DRAIN: done pulses for one cycle and the state returns to IDLE. instr_ready rises in the same cycle as done, so back-to-back accept is possible on the following edge.
- len=1 dot: single read, so shift and dot_prod_en are both 1 in the same cycle.
- rd_idx wraps is impossible: at most 2^LEN_WIDTH-1 reads, and the counter width is sufficient.
- instr_valid outside IDLE: ignored, since ready=0. Inputs may change freely while ready=0.
- Reset mid-instruction: everything aborts immediately, no done pulse, valid pipes cleared.

Optional Feature:
SEQ_PERF_CNT_EN.
- Defined: adds outputs perf_busy_cycles [31:0] and perf_instr_cnt [31:0].
- perf_busy_cycles increments each cycle busy=1; perf_instr_cnt increments on each done. Both saturate at all-ones and are cleared by rst.
- Undefined: ports and logic are absent and the behaviour is otherwise identical.

Decomposition:
- Shared params package: OP_SEL_WIDTH (existing); an enum type seq_state_t with values IDLE, ISSUE, DRAIN.
- One sub-module, valid_delay_line (parameter DEPTH). Instantiated for the elem_valid pipe and the dot_valid countdown.

Test Plan:
- Elementwise add, len=4, accepted at cycle 3: rd_en high cycles 4-7, rd_idx 0..3; elem_valid high cycles 4+1+EXEC_LAT (=7) to 10; done at 11.
- Dot, len=3: rd_en only on phase=0 cycles, 3 pulses two cycles apart; dot_prod_en one cycle after each; shift only with the first; single dot_valid DOT_LAT cycles after the last dot_prod_en; elem_valid never high.
- len=0 elementwise: behaves as len=1, one rd_en, one elem_valid, done.
- Back-to-back: instr_valid held high with two instructions; second accepted the cycle after done; instr_ready=0 throughout the first.
- rst pulsed while in ISSUE, len=8 at rd_idx=3: all outputs 0 asynchronously, instr_ready=1, no done; a new instruction then runs from rd_idx=0.
- With SEQ_PERF_CNT_EN: two len=2 elementwise instructions -> perf_instr_cnt=2 and perf_busy_cycles equal to the total count of busy cycles.
